// File: rtl/ball_ctl.sv
// ball_ctl -- ball motion, wall/goal handling and scoring for a 2-player
// air-hockey play field. All motion happens once per frame tick, a one-cycle
// pulse generated the cycle after vblnk_in rises.
//
// Ports:
//   clk_in       pixel clock
//   rst          asynchronous reset, active-high
//   vblnk_in     vertical blank from the timing chain
//   start        one-cycle game start/restart request
//   hit_valid    one-cycle mallet collision pulse
//   hit_vx/vy    signed 5-bit velocity loaded on hit (-16 saturates to -15)
//   xpos_ball    ball centre x
//   ypos_ball    ball centre y
//   score_left   left player score
//   score_right  right player score
//   goal         one-cycle goal pulse
//   game_over    high while the game is over
//
// Build option: define BALL_FRICTION_EN to decay non-zero velocities by one
// toward zero every FRIC_FRAMES-th tick in play.
module ball_ctl #(
  parameter int unsigned H_SIZE       = 1024,
  parameter int unsigned V_SIZE       = 768,
  parameter int unsigned RADIUS_BALL  = 10,
  parameter int unsigned GOAL_TOP     = 284,
  parameter int unsigned GOAL_BOT     = 484,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned SERVE_SPEED  = 3,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned FRIC_FRAMES  = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic        hit_valid,
  input  logic [4:0]  hit_vx,
  input  logic [4:0]  hit_vy,
  output logic [11:0] xpos_ball,
  output logic [11:0] ypos_ball,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        goal,
  output logic        game_over
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

  localparam logic [11:0]        X_C     = 12'(H_SIZE / 2);
  localparam logic [11:0]        Y_C     = 12'(V_SIZE / 2);
  localparam logic signed [12:0] X_MIN   = 13'(RADIUS_BALL);
  localparam logic signed [12:0] X_MAX   = 13'(H_SIZE - 1 - RADIUS_BALL);
  localparam logic signed [12:0] Y_MIN   = 13'(RADIUS_BALL);
  localparam logic signed [12:0] Y_MAX   = 13'(V_SIZE - 1 - RADIUS_BALL);
  localparam logic [11:0]        G_TOP   = 12'(GOAL_TOP);
  localparam logic [11:0]        G_BOT   = 12'(GOAL_BOT);
  localparam logic signed [4:0]  SERVE_V = 5'(SERVE_SPEED);
  localparam logic [3:0]         WIN     = 4'(WIN_SCORE);
  localparam int unsigned        SCW     = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCW-1:0]     S_LAST  = SCW'(SERVE_FRAMES - 1);

  state_t             state, state_nx;
  logic               vblnk_d, tick;
  logic signed [4:0]  vx, vy, vx_nx, vy_nx;
  logic [11:0]        x_nx, y_nx;
  logic [3:0]         sl_nx, sr_nx;
  logic               serve_dir, serve_dir_nx;
  logic [SCW-1:0]     serve_cnt, serve_cnt_nx;
  logic               goal_nx, game_over_nx;

  // Move evaluation signals
  logic signed [4:0]  vx_eff, vy_eff, vx_ref, vy_ref;
  logic signed [12:0] nx, ny;
  logic [11:0]        x_ref, y_ref;
  logic               in_mouth, goal_l, goal_r, win;

  function automatic logic signed [4:0] sat5(input logic [4:0] v);
    return (v == 5'b10000) ? 5'sb10001 : $signed(v);
  endfunction

`ifdef BALL_FRICTION_EN
  localparam int unsigned    FCW    = $clog2(FRIC_FRAMES + 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FRIC_FRAMES - 1);
  logic [FCW-1:0] fric_cnt, fric_cnt_nx;
  logic           fric_due;

  function automatic logic signed [4:0] toward0(input logic signed [4:0] v);
    if (v > 5'sd0) return v - 5'sd1;
    if (v < 5'sd0) return v + 5'sd1;
    return v;
  endfunction
`endif

  // Wall/goal evaluation for the current tick; a coincident hit replaces the
  // stored velocity before the move is computed.
  always_comb begin
    vx_eff   = hit_valid ? sat5(hit_vx) : vx;
    vy_eff   = hit_valid ? sat5(hit_vy) : vy;
    nx       = $signed({1'b0, xpos_ball}) + $signed({{8{vx_eff[4]}}, vx_eff});
    ny       = $signed({1'b0, ypos_ball}) + $signed({{8{vy_eff[4]}}, vy_eff});
    in_mouth = (ypos_ball >= G_TOP) && (ypos_ball <= G_BOT);
    goal_r   = (nx < X_MIN) && in_mouth;
    goal_l   = (nx > X_MAX) && in_mouth;
    win      = goal_l ? (score_left + 4'd1 == WIN) : (score_right + 4'd1 == WIN);
    x_ref    = nx[11:0];
    vx_ref   = vx_eff;
    if (nx < X_MIN) begin
      x_ref  = X_MIN[11:0];
      vx_ref = -vx_eff;
    end else if (nx > X_MAX) begin
      x_ref  = X_MAX[11:0];
      vx_ref = -vx_eff;
    end
    y_ref  = ny[11:0];
    vy_ref = vy_eff;
    if (ny < Y_MIN) begin
      y_ref  = Y_MIN[11:0];
      vy_ref = -vy_eff;
    end else if (ny > Y_MAX) begin
      y_ref  = Y_MAX[11:0];
      vy_ref = -vy_eff;
    end
  end

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_SERVE;
    end else begin
      unique case (state)
        S_SERVE: if (tick && serve_cnt == S_LAST) state_nx = S_PLAY;
        S_PLAY:  if (tick && (goal_l || goal_r))  state_nx = win ? S_OVER : S_SERVE;
        default: state_nx = state;
      endcase
    end
  end

  // Datapath/output next values
  always_comb begin
    x_nx         = xpos_ball;
    y_nx         = ypos_ball;
    vx_nx        = vx;
    vy_nx        = vy;
    sl_nx        = score_left;
    sr_nx        = score_right;
    serve_dir_nx = serve_dir;
    serve_cnt_nx = serve_cnt;
    goal_nx      = 1'b0;
    game_over_nx = (state_nx == S_OVER);
`ifdef BALL_FRICTION_EN
    fric_cnt_nx  = fric_cnt;
    fric_due     = (fric_cnt == F_LAST);
`endif
    if (start) begin
      x_nx         = X_C;
      y_nx         = Y_C;
      vx_nx        = '0;
      vy_nx        = '0;
      sl_nx        = '0;
      sr_nx        = '0;
      serve_dir_nx = 1'b0;
      serve_cnt_nx = '0;
    end else begin
      unique case (state)
        S_SERVE: if (tick) begin
          if (serve_cnt == S_LAST) begin
            serve_cnt_nx = '0;
            vx_nx        = serve_dir ? -SERVE_V : SERVE_V;
            vy_nx        = 5'sd1;
`ifdef BALL_FRICTION_EN
            fric_cnt_nx  = '0;
`endif
          end else begin
            serve_cnt_nx = serve_cnt + SCW'(1);
          end
        end
        S_PLAY: if (tick) begin
          if (goal_l || goal_r) begin
            goal_nx      = 1'b1;
            if (goal_l && score_left < WIN)  sl_nx = score_left + 4'd1;
            if (goal_r && score_right < WIN) sr_nx = score_right + 4'd1;
            // next serve heads toward the side that just conceded
            serve_dir_nx = goal_r;
            x_nx         = X_C;
            y_nx         = Y_C;
            vx_nx        = '0;
            vy_nx        = '0;
            serve_cnt_nx = '0;
          end else begin
            x_nx  = x_ref;
            y_nx  = y_ref;
            vx_nx = vx_ref;
            vy_nx = vy_ref;
`ifdef BALL_FRICTION_EN
            fric_cnt_nx = fric_due ? '0 : fric_cnt + FCW'(1);
            if (fric_due) begin
              vx_nx = toward0(vx_ref);
              vy_nx = toward0(vy_ref);
            end
`endif
          end
        end else if (hit_valid) begin
          vx_nx = vx_eff;
          vy_nx = vy_eff;
        end
        default: begin
          x_nx = X_C;
          y_nx = Y_C;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vblnk_d     <= 1'b0;
      tick        <= 1'b0;
      xpos_ball   <= X_C;
      ypos_ball   <= Y_C;
      vx          <= '0;
      vy          <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      serve_cnt   <= '0;
      goal        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      vblnk_d     <= vblnk_in;
      tick        <= vblnk_in & ~vblnk_d;
      xpos_ball   <= x_nx;
      ypos_ball   <= y_nx;
      vx          <= vx_nx;
      vy          <= vy_nx;
      score_left  <= sl_nx;
      score_right <= sr_nx;
      serve_dir   <= serve_dir_nx;
      serve_cnt   <= serve_cnt_nx;
      goal        <= goal_nx;
      game_over   <= game_over_nx;
    end
  end

`ifdef BALL_FRICTION_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) fric_cnt <= '0;
    else     fric_cnt <= fric_cnt_nx;
  end
`endif

endmodule

// File: tb/tb_ball_ctl.sv
// Bench for ball_ctl: directed scenarios plus randomized frames, compared
// against an integer game model kept here.
module tb_ball_ctl;
  logic        clk_in = 1'b0;
  logic        rst, vblnk_in, start, hit_valid;
  logic [4:0]  hit_vx, hit_vy;
  logic [11:0] xpos_ball, ypos_ball;
  logic [3:0]  score_left, score_right;
  logic        goal, game_over;

  ball_ctl dut (
    .clk_in(clk_in), .rst(rst), .vblnk_in(vblnk_in), .start(start),
    .hit_valid(hit_valid), .hit_vx(hit_vx), .hit_vy(hit_vy),
    .xpos_ball(xpos_ball), .ypos_ball(ypos_ball),
    .score_left(score_left), .score_right(score_right),
    .goal(goal), .game_over(game_over)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_err    = 0;

  // Game model: modes 0 idle, 1 serve, 2 play, 3 over
  int m_mode, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_dir, m_cnt, m_fric, m_goal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input logic [4:0] v);
    int s;
    s = $signed(v);
    if (s == -16) s = -15;
    return s;
  endfunction

  function automatic int toward0(input int v);
    return (v > 0) ? v - 1 : (v < 0) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 512; m_y = 384; m_vx = 0; m_vy = 0;
    m_sl = 0; m_sr = 0; m_dir = 0; m_cnt = 0; m_fric = 0; m_goal = 0;
  endtask

  task automatic model_start();
    m_mode = 1; m_x = 512; m_y = 384; m_vx = 0; m_vy = 0;
    m_sl = 0; m_sr = 0; m_dir = 0; m_cnt = 0; m_goal = 0;
  endtask

  task automatic model_tick(input bit hv, input logic [4:0] hx, input logic [4:0] hy);
    int nx, ny, scorer;
    m_goal = 0;
    if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_mode = 2; m_cnt = 0; m_fric = 0;
        m_vx = m_dir ? -3 : 3; m_vy = 1;
      end
    end else if (m_mode == 2) begin
      if (hv) begin m_vx = sat(hx); m_vy = sat(hy); end
      nx = m_x + m_vx; ny = m_y + m_vy; scorer = 0;
      if (ny < 10)       begin ny = 10;  m_vy = -m_vy; end
      else if (ny > 757) begin ny = 757; m_vy = -m_vy; end
      if (nx < 10) begin
        if (m_y >= 284 && m_y <= 484) scorer = 2; else begin nx = 10; m_vx = -m_vx; end
      end else if (nx > 1013) begin
        if (m_y >= 284 && m_y <= 484) scorer = 1; else begin nx = 1013; m_vx = -m_vx; end
      end
      if (scorer != 0) begin
        m_goal = 1;
        if (scorer == 1) m_sl++; else m_sr++;
        m_dir = (scorer == 2) ? 1 : 0;
        m_x = 512; m_y = 384; m_vx = 0; m_vy = 0; m_cnt = 0;
        m_mode = ((scorer == 1 ? m_sl : m_sr) == 7) ? 3 : 1;
      end else begin
        m_x = nx; m_y = ny;
`ifdef BALL_FRICTION_EN
        m_fric++;
        if (m_fric % 16 == 0) begin m_vx = toward0(m_vx); m_vy = toward0(m_vy); end
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"}, 32'(xpos_ball), m_x);
    chk({tag, ".y"}, 32'(ypos_ball), m_y);
    chk({tag, ".score_left"}, 32'(score_left), m_sl);
    chk({tag, ".score_right"}, 32'(score_right), m_sr);
    chk({tag, ".game_over"}, 32'(game_over), (m_mode == 3) ? 1 : 0);
    chk({tag, ".goal"}, 32'(goal), m_goal);
  endtask

  // vblnk high one cycle; the tick falls in the following cycle, where an
  // optional hit is driven so it coincides with the tick.
  task automatic frame(input bit hv, input logic [4:0] hx, input logic [4:0] hy, input string tag);
    vblnk_in = 1'b1;
    @(posedge clk_in); #1;
    vblnk_in = 1'b0; hit_valid = hv; hit_vx = hx; hit_vy = hy;
    @(posedge clk_in); #1;
    hit_valid = 1'b0;
    model_tick(hv, hx, hy);
    check_all(tag);
    @(posedge clk_in); #1;
    chk({tag, ".goal_clear"}, 32'(goal), 0);
  endtask

  task automatic hit_only(input logic [4:0] hx, input logic [4:0] hy);
    hit_valid = 1'b1; hit_vx = hx; hit_vy = hy;
    @(posedge clk_in); #1;
    hit_valid = 1'b0;
    if (m_mode == 2) begin m_vx = sat(hx); m_vy = sat(hy); end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    model_start();
    check_all("start");
  endtask

  task automatic serve_wait();
    repeat (60) frame(1'b0, 5'd0, 5'd0, "serve");
  endtask

  // Steer the ball to (tx,ty) with tick-coincident hits that never overshoot.
  task automatic goto(input int tx, input int ty);
    int it, dx, dy;
    it = 0;
    while ((m_x != tx || m_y != ty) && m_mode == 2 && it < 300) begin
      dx = tx - m_x; dy = ty - m_y;
      if (dx > 15) dx = 15; if (dx < -15) dx = -15;
      if (dy > 15) dy = 15; if (dy < -15) dy = -15;
      frame(1'b1, 5'(dx), 5'(dy), "goto");
      it++;
    end
    if (m_x != tx || m_y != ty) begin
      n_checks++; n_err++;
      $display("FAIL goto_reach: ball at (%0d,%0d) required (%0d,%0d)", m_x, m_y, tx, ty);
    end
  endtask

  int px, r;

  initial begin
    rst = 1'b1; vblnk_in = 1'b0; start = 1'b0; hit_valid = 1'b0;
    hit_vx = '0; hit_vy = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all("reset");
    rst = 1'b0;

    // IDLE ignores ticks and hits
    frame(1'b1, 5'd5, 5'd5, "idle");

    // first serve and first move
    do_start();
    serve_wait();
    frame(1'b0, 5'd0, 5'd0, "first_move");
    chk("first_move.x_const", 32'(xpos_ball), 515);
    chk("first_move.y_const", 32'(ypos_ball), 385);

    // left wall outside goal mouth reflects
    goto(12, 100);
    hit_only(5'h1B, 5'd0);
    frame(1'b0, 5'd0, 5'd0, "left_reflect");
    chk("left_reflect.x_const", 32'(xpos_ball), 10);
    frame(1'b0, 5'd0, 5'd0, "left_reflect_next");

    // left wall inside goal mouth: right scores
    goto(12, 384);
    hit_only(5'h1B, 5'd0);
    frame(1'b0, 5'd0, 5'd0, "right_goal");
    chk("right_goal.score_const", 32'(score_right), 1);
    chk("right_goal.x_const", 32'(xpos_ball), 512);
    serve_wait();
    frame(1'b0, 5'd0, 5'd0, "serve_left");
    chk("serve_left.x_const", 32'(xpos_ball), 509);

    // saturated hit coincident with tick
    px = m_x;
    frame(1'b1, 5'h10, 5'd7, "hit_sat");
    chk("hit_sat.dx", 32'(xpos_ball), px - 15);
    frame(1'b0, 5'd0, 5'd0, "hit_sat_next");

    // corner: both reflections on one tick
    goto(12, 12);
    frame(1'b1, 5'h1B, 5'h1B, "corner");
    chk("corner.x_const", 32'(xpos_ball), 10);
    chk("corner.y_const", 32'(ypos_ball), 10);
    frame(1'b0, 5'd0, 5'd0, "corner_next");

    // goal mouth edges use pre-move y
    goto(1010, 484);
    frame(1'b1, 5'd15, 5'd15, "mouth_bot");
    serve_wait();
    goto(1010, 485);
    frame(1'b1, 5'd15, 5'd0, "below_mouth");
    chk("below_mouth.x_const", 32'(xpos_ball), 1013);
    goto(12, 284);
    frame(1'b1, 5'h1B, 5'd0, "mouth_top");
    serve_wait();

    // steady velocity over many ticks (decays if friction is built in)
    goto(200, 200);
    hit_only(5'd3, 5'd0);
    repeat (50) frame(1'b0, 5'd0, 5'd0, "coast");

    // randomized play
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (m_mode == 3 && r < 20) do_start();
      else if (r == 199) do_start();
      else if (r < 30) frame(1'b1, 5'($urandom), 5'($urandom), "rand_hit");
      else if (r < 50) begin
        hit_only(5'($urandom), 5'($urandom));
        frame(1'b0, 5'd0, 5'd0, "rand_after_hit");
      end else frame(1'b0, 5'd0, 5'd0, "rand");
    end

    // left player wins 7-0
    do_start();
    serve_wait();
    for (int g = 0; g < 7; g++) begin
      goto(1010, 300);
      frame(1'b1, 5'd15, 5'd0, "left_goal");
      if (g < 6) serve_wait();
    end
    chk("win.score_const", 32'(score_left), 7);
    chk("win.over_const", 32'(game_over), 1);
    frame(1'b1, 5'd9, 5'd9, "over_hold");
    do_start();
    chk("restart.over_const", 32'(game_over), 0);

    // asynchronous reset mid-game
    serve_wait();
    repeat (5) frame(1'b0, 5'd0, 5'd0, "pre_reset");
    @(posedge clk_in); #3;
    rst = 1'b1; #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk_in); #1;
    rst = 1'b0;
    frame(1'b0, 5'd0, 5'd0, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
